gvt_tracker: RTL and testbench

- Sequential stage directly downstream of the combinational GVT monitor.
- Registers the monitor's `gvt` and enforces monotonic advance.
- Broadcasts each GVT increase to the fossil-collection/commit logic over a valid/ready handshake.
- Detects simulation termination: GVT reached the end time, or the system stays quiescent.

---
 rtl/gvt_tracker.sv | 150 +++++++++++++++
 tb/tb_gvt_tracker.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gvt_tracker.sv
// GVT tracker: registers the monitor's GVT, enforces monotonic advance,
// broadcasts each increase over valid/ready and detects run termination.
module gvt_tracker #(
    parameter int unsigned NUM_CORE  = 4,
    parameter int unsigned TIME_WID  = 16,
    parameter int unsigned QUIET_CYC = 8,
    parameter int unsigned CNT_WID   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TIME_WID-1:0] sim_end_time,
    input  logic [TIME_WID-1:0] gvt_in,
    input  logic [NUM_CORE-1:0] core_vld,
    input  logic                queue_empty,
    output logic [TIME_WID-1:0] gvt,
    output logic                gvt_bcast_vld,
    input  logic                gvt_bcast_rdy,
    output logic                running,
    output logic                done,
    output logic                gvt_err,
    output logic [CNT_WID-1:0]  bcast_count
);

    localparam int unsigned   QW        = $clog2(QUIET_CYC + 1);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_BCAST,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [TIME_WID-1:0] gvt_nxt;
    logic                vld_nxt;
    logic                done_nxt;
    logic                err_nxt;
    logic [CNT_WID-1:0]  cnt_nxt;
    logic [QW-1:0]       quiet_cnt, quiet_nxt, quiet_upd;
    logic                term_pend, pend_nxt;
    logic [TIME_WID-1:0] end_time, end_nxt;
    logic                is_quiet;
    logic                term;

    // State and registered outputs; reset cancels any in-flight broadcast
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            gvt           <= '0;
            gvt_bcast_vld <= 1'b0;
            done          <= 1'b0;
            gvt_err       <= 1'b0;
            bcast_count   <= '0;
            quiet_cnt     <= '0;
            term_pend     <= 1'b0;
            end_time      <= '0;
        end else begin
            state         <= state_nxt;
            gvt           <= gvt_nxt;
            gvt_bcast_vld <= vld_nxt;
            done          <= done_nxt;
            gvt_err       <= err_nxt;
            bcast_count   <= cnt_nxt;
            quiet_cnt     <= quiet_nxt;
            term_pend     <= pend_nxt;
            end_time      <= end_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt = state;
        gvt_nxt   = gvt;
        vld_nxt   = gvt_bcast_vld;
        done_nxt  = done;
        err_nxt   = gvt_err;
        cnt_nxt   = bcast_count;
        quiet_nxt = quiet_cnt;
        pend_nxt  = term_pend;
        end_nxt   = end_time;

        // The quiet count includes the current cycle, so the QUIET_CYC-th
        // consecutive quiet cycle is the one that terminates.
        is_quiet  = queue_empty && (core_vld == '0);
        if (!is_quiet)
            quiet_upd = '0;
        else if (quiet_cnt == QUIET_MAX)
            quiet_upd = quiet_cnt;
        else
            quiet_upd = quiet_cnt + QW'(1);
        term = (gvt >= end_time) || (quiet_upd == QUIET_MAX);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    gvt_nxt   = '0;
                    vld_nxt   = 1'b0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    quiet_nxt = '0;
                    pend_nxt  = 1'b0;
                    end_nxt   = sim_end_time;
                end
            end
            S_RUN: begin
                quiet_nxt = quiet_upd;
                if (gvt_in > gvt) begin
                    gvt_nxt   = gvt_in;
                    vld_nxt   = 1'b1;
                    state_nxt = S_BCAST;
                    if (term)
                        pend_nxt = 1'b1;
                end else begin
                    if (gvt_in < gvt)
                        err_nxt = 1'b1;
                    if (term)
                        state_nxt = S_DRAIN;
                end
            end
            S_BCAST: begin
                if (gvt_bcast_rdy) begin
                    vld_nxt = 1'b0;
                    cnt_nxt = bcast_count + CNT_WID'(1);
                    if (term_pend || (gvt >= end_time))
                        state_nxt = S_DRAIN;
                    else
                        state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (core_vld == '0) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Running is a pure decode of the state
    always_comb begin
        running = (state == S_RUN) || (state == S_BCAST);
    end

endmodule

// File: tb/tb_gvt_tracker.sv
// Self-checking bench for gvt_tracker: directed scenarios plus random
// stimulus, all compared against a flag-based behavioural model.
module tb_gvt_tracker;

    localparam int NC = 4;
    localparam int TW = 16;
    localparam int QC = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] sim_end_time;
    logic [TW-1:0] gvt_in;
    logic [NC-1:0] core_vld;
    logic          queue_empty;
    logic [TW-1:0] gvt;
    logic          gvt_bcast_vld;
    logic          gvt_bcast_rdy;
    logic          running;
    logic          done;
    logic          gvt_err;
    logic [CW-1:0] bcast_count;

    int total = 0;
    int bad   = 0;

    gvt_tracker #(
        .NUM_CORE (NC),
        .TIME_WID (TW),
        .QUIET_CYC(QC),
        .CNT_WID  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sim_end_time (sim_end_time),
        .gvt_in       (gvt_in),
        .core_vld     (core_vld),
        .queue_empty  (queue_empty),
        .gvt          (gvt),
        .gvt_bcast_vld(gvt_bcast_vld),
        .gvt_bcast_rdy(gvt_bcast_rdy),
        .running      (running),
        .done         (done),
        .gvt_err      (gvt_err),
        .bcast_count  (bcast_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: activity described by flags rather than a state code
    logic [TW-1:0] m_gvt, m_end;
    logic [CW-1:0] m_cnt;
    bit            m_active, m_offer, m_drain, m_done, m_err, m_pend;
    int            m_quiet;

    task automatic model_reset();
        m_gvt = '0; m_end = '0; m_cnt = '0;
        m_active = 0; m_offer = 0; m_drain = 0; m_done = 0; m_err = 0; m_pend = 0;
        m_quiet = 0;
    endtask

    task automatic model_step();
        int  q;
        bit  t;
        if (rst) begin
            model_reset();
        end else if (!m_active && !m_drain) begin
            if (start) begin
                m_active = 1; m_offer = 0; m_gvt = '0; m_err = 0; m_cnt = '0;
                m_quiet = 0; m_pend = 0; m_done = 0; m_end = sim_end_time;
            end
        end else if (m_drain) begin
            if (core_vld == '0) begin
                m_drain = 0;
                m_done  = 1;
            end
        end else if (m_offer) begin
            if (gvt_bcast_rdy) begin
                m_offer = 0;
                m_cnt   = m_cnt + 1;
                if (m_pend || m_gvt >= m_end) begin
                    m_active = 0;
                    m_drain  = 1;
                end
            end
        end else begin
            q = (queue_empty && core_vld == '0) ? ((m_quiet < QC) ? m_quiet + 1 : QC) : 0;
            t = (m_gvt >= m_end) || (q == QC);
            m_quiet = q;
            if (gvt_in > m_gvt) begin
                m_gvt   = gvt_in;
                m_offer = 1;
                if (t) m_pend = 1;
            end else begin
                if (gvt_in < m_gvt) m_err = 1;
                if (t) begin
                    m_active = 0;
                    m_drain  = 1;
                end
            end
        end
    endtask

    function automatic logic [TW+CW+3:0] dut_vec();
        return {gvt, gvt_bcast_vld, running, done, gvt_err, bcast_count};
    endfunction

    function automatic logic [TW+CW+3:0] model_vec();
        return {m_gvt, m_offer, m_active, m_done, m_err, m_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL reset[%0d]: got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        total++;
        if (dut_vec() !== '0) begin
            bad++;
            $display("FAIL reset_zero: got=%h exp=0", dut_vec());
        end
        rst = 0;
    endtask

    task automatic test_basic();
        sim_end_time = 100; gvt_in = 5; gvt_bcast_rdy = 1; core_vld = 4'b0001; queue_empty = 0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 0);
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL basic[%0d]: got=%h exp=%h", i, dut_vec(), model_vec());
            end
            if (i == 1) begin
                total++;
                if (gvt !== 16'd5 || gvt_bcast_vld !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_first_bcast: gvt=%0d vld=%b exp 5/1", gvt, gvt_bcast_vld);
                end
            end
        end
        start = 0;
        total++;
        if (bcast_count !== 32'd1 || gvt_bcast_vld !== 1'b0 || running !== 1'b1) begin
            bad++;
            $display("FAIL basic_hold: cnt=%0d vld=%b run=%b exp 1/0/1", bcast_count, gvt_bcast_vld, running);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 7; i++) begin
            gvt_in        = (i == 0) ? 16'd10 : 16'd20;
            gvt_bcast_rdy = (i >= 4);
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL backpressure[%0d]: got=%h exp=%h", i, dut_vec(), model_vec());
            end
            if (i <= 3) begin
                total++;
                if (gvt !== 16'd10 || gvt_bcast_vld !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_hold[%0d]: gvt=%0d vld=%b exp 10/1", i, gvt, gvt_bcast_vld);
                end
            end
            if (i == 5) begin
                total++;
                if (gvt !== 16'd20 || gvt_bcast_vld !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_second: gvt=%0d vld=%b exp 20/1", gvt, gvt_bcast_vld);
                end
            end
        end
        total++;
        if (bcast_count !== 32'd3 || gvt_bcast_vld !== 1'b0) begin
            bad++;
            $display("FAIL bp_count: cnt=%0d vld=%b exp 3/0", bcast_count, gvt_bcast_vld);
        end
    endtask

    task automatic test_regress();
        gvt_in = 15;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL regress[%0d]: got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        total++;
        if (gvt_err !== 1'b1 || gvt !== 16'd20 || gvt_bcast_vld !== 1'b0 || bcast_count !== 32'd3) begin
            bad++;
            $display("FAIL regress_err: err=%b gvt=%0d vld=%b cnt=%0d exp 1/20/0/3",
                     gvt_err, gvt, gvt_bcast_vld, bcast_count);
        end
    endtask

    task automatic test_end_time();
        gvt_in = 100; gvt_bcast_rdy = 1; queue_empty = 0;
        for (int i = 0; i < 5; i++) begin
            core_vld = (i < 4) ? 4'b0010 : 4'b0000;
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL end_time[%0d]: got=%h exp=%h", i, dut_vec(), model_vec());
            end
            if (i == 3) begin
                total++;
                if (done !== 1'b0 || running !== 1'b0) begin
                    bad++;
                    $display("FAIL end_drain: done=%b run=%b exp 0/0", done, running);
                end
            end
        end
        total++;
        if (done !== 1'b1 || running !== 1'b0 || gvt !== 16'd100 || bcast_count !== 32'd4) begin
            bad++;
            $display("FAIL end_done: done=%b run=%b gvt=%0d cnt=%0d exp 1/0/100/4",
                     done, running, gvt, bcast_count);
        end
    endtask

    task automatic test_quiet();
        sim_end_time = 1000; gvt_in = 40; queue_empty = 1; gvt_bcast_rdy = 1;
        for (int i = 0; i < 17; i++) begin
            start    = (i == 0);
            core_vld = (i < 3 || i == 7) ? 4'b0001 : 4'b0000;
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL quiet[%0d]: got=%h exp=%h", i, dut_vec(), model_vec());
            end
            if (i == 14) begin
                total++;
                if (running !== 1'b1) begin
                    bad++;
                    $display("FAIL quiet_restart: run=%b exp 1", running);
                end
            end
            if (i == 15) begin
                total++;
                if (running !== 1'b0 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL quiet_drain: run=%b done=%b exp 0/0", running, done);
                end
            end
        end
        total++;
        if (done !== 1'b1 || gvt !== 16'd40) begin
            bad++;
            $display("FAIL quiet_done: done=%b gvt=%0d exp 1/40", done, gvt);
        end
    endtask

    task automatic test_reset_mid_bcast();
        sim_end_time = 1000; gvt_in = 50; gvt_bcast_rdy = 0; core_vld = 4'b0001; queue_empty = 0;
        for (int i = 0; i < 2; i++) begin
            start = (i == 0);
            step();
        end
        start = 0;
        total++;
        if (gvt_bcast_vld !== 1'b1 || gvt !== 16'd50) begin
            bad++;
            $display("FAIL rstb_pre: vld=%b gvt=%0d exp 1/50", gvt_bcast_vld, gvt);
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== '0) begin
            bad++;
            $display("FAIL rstb_async: got=%h exp=0", dut_vec());
        end
        step();
        rst = 0;
        gvt_bcast_rdy = 1;
        for (int j = 0; j < 6; j++) begin
            start        = (j == 0 || j == 4);
            sim_end_time = (j == 4) ? 16'd0 : 16'd1000;
            gvt_in       = (j >= 3) ? 16'd30 : 16'd50;
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL rstb_restart[%0d]: got=%h exp=%h", j, dut_vec(), model_vec());
            end
        end
        start = 0;
        total++;
        if (running !== 1'b1 || gvt !== 16'd50 || gvt_err !== 1'b1 || bcast_count !== 32'd1) begin
            bad++;
            $display("FAIL rstb_ignore_start: run=%b gvt=%0d err=%b cnt=%0d exp 1/50/1/1",
                     running, gvt, gvt_err, bcast_count);
        end
    endtask

    task automatic test_edges();
        rst = 1;
        step();
        rst = 0;
        sim_end_time = 0; gvt_in = 0; core_vld = '0; queue_empty = 0; gvt_bcast_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            start = (i == 0);
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL end_zero[%0d]: got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        total++;
        if (done !== 1'b1 || bcast_count !== 32'd0) begin
            bad++;
            $display("FAIL end_zero_done: done=%b cnt=%0d exp 1/0", done, bcast_count);
        end
        sim_end_time = 16'hFFFF; gvt_in = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            start = (k == 0);
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL all_ones[%0d]: got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        start = 0;
        total++;
        if (gvt !== 16'hFFFF || done !== 1'b1 || bcast_count !== 32'd1) begin
            bad++;
            $display("FAIL all_ones_done: gvt=%h done=%b cnt=%0d exp ffff/1/1", gvt, done, bcast_count);
        end
    endtask

    task automatic test_random();
        gvt_in = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!m_active && !m_drain) begin
                start = ($urandom_range(0, 2) == 0);
                if (start) gvt_in = TW'($urandom_range(0, 20));
            end else begin
                start = ($urandom_range(0, 24) == 0);
            end
            sim_end_time = TW'($urandom_range(0, 400));
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) == 0)
                    gvt_in = gvt_in - TW'($urandom_range(0, 40));
                else
                    gvt_in = gvt_in + TW'($urandom_range(0, 30));
            end
            core_vld      = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
            queue_empty   = ($urandom_range(0, 6) != 0);
            gvt_bcast_rdy = ($urandom_range(0, 2) != 0);
            step();
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL random[%0d]: got=%h exp=%h", n, dut_vec(), model_vec());
            end
        end
        rst = 0;
        start = 0;
    endtask

    initial begin
        rst = 1; start = 0; sim_end_time = '0; gvt_in = '0;
        core_vld = '0; queue_empty = 0; gvt_bcast_rdy = 0;
        model_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_regress();
        test_end_time();
        test_quiet();
        test_reset_mid_bcast();
        test_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
